// File: rtl/nn_scale_pkg.sv
// Purpose: shared types and width helpers for the nearest-neighbour scale engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nn_scale_pkg;

  // Engine sequencing: launch, stream reads, wait for the tail, one-cycle done.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // MODE input encodings.
  localparam logic MODE_ZOOM_IN  = 1'b0;  // replicate source pixels
  localparam logic MODE_ZOOM_OUT = 1'b1;  // decimate source pixels

  // Source address width for a w x h frame (never narrower than 1 bit).
  function automatic int ra_width(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

  // Destination address width: sized for the largest (zoom-in) output frame.
  function automatic int wa_width(input int w, input int h, input int s);
    return ra_width(w << s, h << s);
  endfunction

endpackage

// File: rtl/nn_out_fifo.sv
// Purpose: small synchronous FIFO with occupancy count, used as the write-side buffer.
// Latency: a pushed word is visible at the head on the cycle after the push.
// Backpressure: head is held until rd_rdy; a push while full is accepted only with a same-cycle pop.
//
// Ports:
//   core_clk, arst_n    clock, asynchronous active-low reset
//   wr_vld, wr_dat      push strobe and data
//   rd_rdy              consumer accepts the head word this cycle
//   rd_vld, rd_dat      head word present / head data
//   count               current occupancy (0..DEPTH)
module nn_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             core_clk,
  input  logic             arst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rd_vld  = (count != '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = rd_vld && rd_rdy;
  assign do_push = wr_vld && (!full || do_pop);
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only words below count are ever observed.
  always_ff @(posedge core_clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/nn_scale_engine.sv
// Purpose: walks every output pixel of a 2^SHIFT zoom-in/zoom-out frame, reads the source, writes the destination.
// Latency: first R_EN one cycle after START, first W_EN RD_LATENCY+2 cycles after START.
// Backpressure: W_READY low holds the FIFO head; reads stop once FIFO occupancy plus in-flight reads reach RD_LATENCY+2.
//
// Ports:
//   CLK, RESET_N              clock, asynchronous active-low reset
//   START, MODE               launch pulse (IDLE only); 0 zoom-in, 1 zoom-out, latched on START
//   BUSY, DONE                frame in progress; one-cycle completion pulse
//   R_EN, R_ADDR, PIXEL_IN    source read strobe/address; data returns RD_LATENCY cycles later
//   W_EN, W_READY             destination write strobe and acceptance
//   W_ADDR, PIXEL_OUT         destination address and data (held while W_READY is low)
module nn_scale_engine
  import nn_scale_pkg::*;
#(
  parameter int IMG_W_IN   = 160,
  parameter int IMG_H_IN   = 120,
  parameter int SHIFT      = 1,
  parameter int RD_LATENCY = 2,
  parameter int PIX_W      = 8,
  localparam int RA_W = ra_width(IMG_W_IN, IMG_H_IN),
  localparam int WA_W = wa_width(IMG_W_IN, IMG_H_IN, SHIFT)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic             MODE,
  output logic             BUSY,
  output logic             DONE,
  output logic             R_EN,
  output logic [RA_W-1:0]  R_ADDR,
  input  logic [PIX_W-1:0] PIXEL_IN,
  output logic             W_EN,
  input  logic             W_READY,
  output logic [WA_W-1:0]  W_ADDR,
  output logic [PIX_W-1:0] PIXEL_OUT
);

  localparam int W_OUT_UP = IMG_W_IN << SHIFT;
  localparam int H_OUT_UP = IMG_H_IN << SHIFT;
  localparam int W_OUT_DN = IMG_W_IN >> SHIFT;
  localparam int H_OUT_DN = IMG_H_IN >> SHIFT;
  localparam int ROW_DN   = IMG_W_IN << SHIFT;   // source rows skipped per output row when decimating
  localparam int XW       = $clog2(W_OUT_UP);
  localparam int YW       = $clog2(H_OUT_UP);
  localparam int DEPTH    = RD_LATENCY + 2;
  localparam int FCW      = $clog2(DEPTH + 1);
  localparam int CW       = FCW + 1;
  localparam int FW       = WA_W + PIX_W;

  state_t            state_q, state_d;
  logic              mode_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [RA_W-1:0]   row_base_q;
  logic [WA_W-1:0]   wa_q;
  logic              x_last, y_last;
  logic [XW+SHIFT-1:0] x_ext;
  logic [RA_W-1:0]   col;
  logic              rd_fire;
  logic              busy, done;

  // Read-return tracking: valid bit and destination address per read in flight.
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [WA_W-1:0]       pipe_wa [RD_LATENCY];

  logic              fifo_vld;
  logic              fifo_pop;
  logic [FW-1:0]     fifo_dout;
  logic [FCW-1:0]    fifo_count;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     pending;
  logic              credit_ok;
  logic              drain_done;

  // ---------------------------------------------------------------- address generation
  assign x_last = (mode_q == MODE_ZOOM_OUT) ? (x_q == XW'(W_OUT_DN - 1)) : (x_q == XW'(W_OUT_UP - 1));
  assign y_last = (mode_q == MODE_ZOOM_OUT) ? (y_q == YW'(H_OUT_DN - 1)) : (y_q == YW'(H_OUT_UP - 1));

  // Column offset is pure wiring; zero-extend first so the left shift cannot drop bits.
  assign x_ext  = {{SHIFT{1'b0}}, x_q};
  assign col    = (mode_q == MODE_ZOOM_OUT) ? RA_W'(x_ext << SHIFT) : RA_W'(x_ext >> SHIFT);
  assign R_ADDR = row_base_q + col;
  assign R_EN   = rd_fire;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_q     <= MODE_ZOOM_IN;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      wa_q       <= '0;
    end else if (state_q == IDLE) begin
      if (START) begin
        mode_q     <= MODE;
        x_q        <= '0;
        y_q        <= '0;
        row_base_q <= '0;
        wa_q       <= '0;
      end
    end else if (rd_fire) begin
      wa_q <= wa_q + WA_W'(1);
      if (!x_last) begin
        x_q <= x_q + XW'(1);
      end else begin
        x_q <= '0;
        if (y_last) begin
          // Frame complete: park everything at zero for the next launch.
          y_q        <= '0;
          row_base_q <= '0;
          wa_q       <= '0;
        end else begin
          y_q <= y_q + YW'(1);
          // Zoom-in moves to the next source row only every 2^SHIFT output rows.
          if (mode_q == MODE_ZOOM_OUT)
            row_base_q <= row_base_q + RA_W'(ROW_DN);
          else if (&y_q[SHIFT-1:0])
            row_base_q <= row_base_q + RA_W'(IMG_W_IN);
        end
      end
    end
  end

  // ---------------------------------------------------------------- latency pipe
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_wa[i] <= '0;
    end else begin
      pipe_vld[0] <= rd_fire;
      pipe_wa[0]  <= wa_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_wa[i]  <= pipe_wa[i-1];
      end
    end
  end

  // ---------------------------------------------------------------- output FIFO and credits
  nn_out_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_out_fifo (
    .core_clk (CLK),
    .arst_n   (RESET_N),
    .wr_vld   (pipe_vld[RD_LATENCY-1]),
    .wr_dat   ({pipe_wa[RD_LATENCY-1], PIXEL_IN}),
    .rd_rdy   (W_READY),
    .rd_vld   (fifo_vld),
    .rd_dat   (fifo_dout),
    .count    (fifo_count)
  );

  assign fifo_pop  = fifo_vld && W_READY;
  assign W_EN      = fifo_vld;
  // Gated so the outputs read zero whenever nothing is offered (including reset).
  assign W_ADDR    = fifo_vld ? fifo_dout[PIX_W +: WA_W] : '0;
  assign PIXEL_OUT = fifo_vld ? fifo_dout[PIX_W-1:0]     : '0;

  // Every in-flight read owns a FIFO slot, so the FIFO can never overflow.
  assign inflight  = CW'($countones(pipe_vld));
  assign pending   = CW'(fifo_count) + inflight;
  assign credit_ok = (pending < CW'(DEPTH));

  // Leave DRAIN on the cycle the final word is popped so DONE follows the last write directly.
  assign drain_done = (pipe_vld == '0) &&
                      ((fifo_count == '0) || ((fifo_count == FCW'(1)) && fifo_pop));

  // ---------------------------------------------------------------- control FSM
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    rd_fire = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (START) state_d = RUN;
      end
      RUN: begin
        rd_fire = credit_ok;
        if (credit_ok && x_last && y_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign BUSY = busy;
  assign DONE = done;

endmodule
